// File: rtl/baud_pkg.sv
// Shared types and elaboration-time helpers for the fractional baud generator.
package baud_pkg;

  typedef enum logic [1:0] {
    STOPPED = 2'd0,
    RUNNING = 2'd1,
    PENDING = 2'd2
  } baud_state_e;

  // Ceiling log2; 0 for values of 0 or 1.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned w;
    w = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) w = i + 1;
    end
    return w;
  endfunction

  // round(baud * os * 2^w / clk_hz), evaluated at elaboration.
  function automatic logic [63:0] baud_incr(input longint unsigned clk_hz,
                                             input longint unsigned baud,
                                             input longint unsigned os,
                                             input longint unsigned w);
    longint unsigned num;
    num = (baud * os) << w;
    return (num + clk_hz / 2) / clk_hz;
  endfunction

endpackage

// File: rtl/baud_os_div.sv
// OVERSAMPLE wrap counter: counts tick_i and flags the tick that returns the count to 0.
module baud_os_div
  import baud_pkg::*;
#(
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic tick_i,
  input  logic clear_i,
  output logic wrap_c_o
);

  localparam int unsigned DIV_W = clog2(OVERSAMPLE);
  localparam logic [DIV_W-1:0] LAST = DIV_W'(OVERSAMPLE - 1);

  logic [DIV_W-1:0] cnt_q, cnt_d;

  assign wrap_c_o = tick_i && (cnt_q == LAST);

  // Clear wins over a coincident tick.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (tick_i) begin
      cnt_d = wrap_c_o ? '0 : cnt_q + DIV_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/baud_gen_frac.sv
// Fractional phase-accumulator baud generator with rx resync and tx-boundary config reload.
// Optional BAUD_GEN_FRAC_TICK_CNT_EN adds a 16-bit free-running txclk_en counter output.
module baud_gen_frac
  import baud_pkg::*;
#(
  parameter int unsigned CLK_HZ       = 50000000,
  parameter int unsigned DEFAULT_BAUD = 115200,
  parameter int unsigned OVERSAMPLE   = 16,
  parameter int unsigned ACC_WIDTH    = 24
) (
  input  logic                 clk_50m,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 rx_resync,
  input  logic [ACC_WIDTH-1:0] cfg_incr,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  output logic                 rxclk_en,
  output logic                 txclk_en,
  output logic [ACC_WIDTH-1:0] incr_q
`ifdef BAUD_GEN_FRAC_TICK_CNT_EN
  ,
  output logic [15:0]          tx_tick_cnt
`endif
);

  localparam logic [ACC_WIDTH-1:0] DEFAULT_INCR =
    ACC_WIDTH'(baud_incr(64'(CLK_HZ), 64'(DEFAULT_BAUD), 64'(OVERSAMPLE), 64'(ACC_WIDTH)));
  localparam logic [ACC_WIDTH-1:0] HALF_PHASE = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  baud_state_e          state_q, state_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d, incr_d;
  logic [ACC_WIDTH:0]   sum_c;
  logic active_c, resync_c, carry_c, wrap_c, div_clear_c;
  logic stop_accept_c, pend_accept_c, accept_c, rx_d, tx_d;

  assign active_c = enable && (state_q != STOPPED);
  assign resync_c = active_c && rx_resync;
  assign sum_c    = {1'b0, acc_q} + {1'b0, incr_q};
  assign carry_c  = active_c && sum_c[ACC_WIDTH];

  // wrap_c marks the carry that closes a tx bit (raw, before resync suppression).
  baud_os_div #(
    .OVERSAMPLE(OVERSAMPLE)
  ) u_os_div (
    .clk_i   (clk_50m),
    .rst_i   (rst),
    .tick_i  (carry_c),
    .clear_i (div_clear_c),
    .wrap_c_o(wrap_c)
  );

  always_ff @(posedge clk_50m) begin
    if (rst) state_q <= STOPPED;
    else     state_q <= state_d;
  end

  // cfg_ready high means the held request was just consumed; do not take it twice.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      STOPPED: if (enable) state_d = RUNNING;
      RUNNING: begin
        if (!enable)                      state_d = STOPPED;
        else if (cfg_valid && !cfg_ready) state_d = PENDING;
      end
      PENDING: begin
        if (!enable)                 state_d = STOPPED;
        else if (!cfg_valid || wrap_c) state_d = RUNNING;
      end
      default: state_d = STOPPED;
    endcase
  end

  always_comb begin
    acc_d         = acc_q;
    incr_d        = incr_q;
    stop_accept_c = (state_q == STOPPED) && cfg_valid && !cfg_ready;
    pend_accept_c = (state_q == PENDING) && active_c && cfg_valid && wrap_c;
    accept_c      = stop_accept_c || pend_accept_c;
    div_clear_c   = stop_accept_c || resync_c;
    rx_d          = carry_c && !resync_c;
    tx_d          = wrap_c && !resync_c;
    if (stop_accept_c) begin
      acc_d = '0;
    end else if (resync_c) begin
      acc_d = HALF_PHASE;
    end else if (active_c) begin
      acc_d = sum_c[ACC_WIDTH-1:0];
    end
    if (accept_c) incr_d = cfg_incr;
  end

  always_ff @(posedge clk_50m) begin
    if (rst) begin
      acc_q     <= '0;
      incr_q    <= DEFAULT_INCR;
      rxclk_en  <= 1'b0;
      txclk_en  <= 1'b0;
      cfg_ready <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      incr_q    <= incr_d;
      rxclk_en  <= rx_d;
      txclk_en  <= tx_d;
      cfg_ready <= accept_c;
    end
  end

`ifdef BAUD_GEN_FRAC_TICK_CNT_EN
  always_ff @(posedge clk_50m) begin
    if (rst)       tx_tick_cnt <= '0;
    else if (tx_d) tx_tick_cnt <= tx_tick_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_baud_gen_frac.sv
// Self-checking bench for baud_gen_frac: directed scenarios plus randomized traffic vs a phase model.
module tb_baud_gen_frac;

  localparam int unsigned     ACC_W    = 24;
  localparam int unsigned     OS       = 16;
  localparam longint unsigned FULL     = 64'd1 << ACC_W;
  localparam longint unsigned DEF_INCR = 64'd618475;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             enable = 1'b0;
  logic             rx_resync = 1'b0;
  logic             cfg_valid = 1'b0;
  logic [ACC_W-1:0] cfg_incr = '0;
  logic             cfg_ready, rxclk_en, txclk_en;
  logic [ACC_W-1:0] incr_q;
`ifdef BAUD_GEN_FRAC_TICK_CNT_EN
  logic [15:0]      tx_tick_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_on  = 1'b0;

  always #5 clk = ~clk;

  baud_gen_frac dut (
    .clk_50m    (clk),
    .rst        (rst),
    .enable     (enable),
    .rx_resync  (rx_resync),
    .cfg_incr   (cfg_incr),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .rxclk_en   (rxclk_en),
    .txclk_en   (txclk_en),
    .incr_q     (incr_q)
`ifdef BAUD_GEN_FRAC_TICK_CNT_EN
    ,
    .tx_tick_cnt(tx_tick_cnt)
`endif
  );

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: phase as an integer fraction of FULL, rx ticks counted since last realign.
  int unsigned     m_mode  = 0;   // 0 stopped, 1 running, 2 pending
  longint unsigned m_phase = 0;
  longint unsigned m_incr  = DEF_INCR;
  int unsigned     m_rxcnt = 0;
  bit              e_rx = 1'b0, e_tx = 1'b0, e_rdy = 1'b0;
  logic [15:0]     e_txcnt = '0;

  always @(posedge clk) begin : ref_model
    bit run, ovf, rs, bnd, take, prev_rdy;
    longint unsigned nxt;
    if (rst) begin
      m_mode = 0; m_phase = 0; m_incr = DEF_INCR; m_rxcnt = 0;
      e_rx = 1'b0; e_tx = 1'b0; e_rdy = 1'b0; e_txcnt = '0;
    end else begin
      prev_rdy = e_rdy;
      run  = enable && (m_mode != 0);
      nxt  = m_phase + m_incr;
      ovf  = run && (nxt >= FULL);
      rs   = run && rx_resync;
      bnd  = ovf && (((m_rxcnt + 1) % OS) == 0);
      take = (m_mode == 0 && cfg_valid && !prev_rdy) || (m_mode == 2 && run && cfg_valid && bnd);
      e_rx = ovf && !rs;
      e_tx = bnd && !rs;
      if (e_tx) e_txcnt = e_txcnt + 16'd1;
      if (m_mode == 0 && take) begin
        m_phase = 0; m_rxcnt = 0;
      end else if (rs) begin
        m_phase = FULL / 2; m_rxcnt = 0;
      end else if (run) begin
        m_phase = nxt % FULL;
        if (ovf) m_rxcnt++;
      end
      if (take) m_incr = 64'(cfg_incr);
      e_rdy = take;
      case (m_mode)
        0:       m_mode = enable ? 1 : 0;
        1:       m_mode = !enable ? 0 : ((cfg_valid && !prev_rdy) ? 2 : 1);
        default: m_mode = !enable ? 0 : ((!cfg_valid || bnd) ? 1 : 2);
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk_eq("cycle", 64'({rxclk_en, txclk_en, cfg_ready, incr_q}),
             64'({e_rx, e_tx, e_rdy, ACC_W'(m_incr)}));
`ifdef BAUD_GEN_FRAC_TICK_CNT_EN
      chk_eq("tx_tick_cnt", 64'(tx_tick_cnt), 64'(e_txcnt));
`endif
    end
  end

  task automatic wait_tx(input int limit, output int n, output int rx);
    n = 0; rx = 0;
    do begin
      @(negedge clk);
      n++;
      rx += int'(rxclk_en);
    end while (!txclk_en && n < limit);
    chk_eq("tx_seen", 64'(txclk_en), 64'd1);
  endtask

  function automatic logic [ACC_W-1:0] rand_incr();
    if ($urandom_range(0, 3) == 0) return ACC_W'($urandom_range(32'h200000, 32'h800000));
    return ACC_W'($urandom_range(32'h800000, 32'hFFFFFF));
  endfunction

  initial begin
    int n, r, r1, cnt, rxc;
    longint unsigned exp_s;

    repeat (3) @(negedge clk);
    chk_eq("rst_outs", 64'({rxclk_en, txclk_en, cfg_ready}), 64'd0);
    chk_eq("rst_incr", 64'(incr_q), 64'd618475);
    rst = 1'b0;
    chk_on = 1'b1;

    // Defaults: k-th rx tick lands ceil(k*2^W/incr) accumulate cycles after start.
    enable = 1'b1;
    n = 0; rxc = 0; cnt = 0;
    while (cnt < 100 && n < 50000) begin
      @(negedge clk);
      n++;
      rxc += int'(rxclk_en);
      cnt += int'(txclk_en);
    end
    exp_s = (1600 * FULL + DEF_INCR - 1) / DEF_INCR + 1;
    chk_eq("def_100th_tx_cycle", 64'(n), 64'(exp_s));
    chk_eq("def_rx_count", 64'(rxc), 64'd1600);

    // Load 2^23 while stopped.
    enable = 1'b0;
    repeat (3) @(negedge clk);
    cfg_incr = 24'h800000; cfg_valid = 1'b1;
    @(negedge clk);
    chk_eq("stop_cfg_ready", 64'(cfg_ready), 64'd1);
    chk_eq("stop_cfg_incr", 64'(incr_q), 64'h800000);
    cfg_valid = 1'b0;
    enable = 1'b1;
    wait_tx(100, n, r);
    wait_tx(100, n, r);
    chk_eq("tx_period_2p23", 64'(n), 64'd32);
    chk_eq("rx_per_bit_2p23", 64'(r), 64'd16);

    // Resync mid-bit.
    repeat (5) @(negedge clk);
    rx_resync = 1'b1;
    @(negedge clk);
    rx_resync = 1'b0;
    chk_eq("resync_suppress", 64'(rxclk_en), 64'd0);
    @(negedge clk);
    chk_eq("resync_first_rx", 64'(rxclk_en), 64'd1);
    wait_tx(100, n, r);
    chk_eq("resync_tx_delay", 64'(n + 2), 64'd32);

    // Hold mid-bit for 100 cycles; phase must resume where it stopped.
    r1 = 0;
    repeat (7) begin @(negedge clk); r1 += int'(rxclk_en); end
    enable = 1'b0;
    cnt = 0;
    repeat (100) begin @(negedge clk); cnt += int'(rxclk_en) + int'(txclk_en); end
    chk_eq("hold_no_ticks", 64'(cnt), 64'd0);
    enable = 1'b1;
    wait_tx(200, n, r);
    chk_eq("hold_bit_rx_total", 64'(r1 + r), 64'd16);

    // Mid-bit reload to 2^22 only lands on a tx boundary.
    repeat (5) @(negedge clk);
    cfg_incr = 24'h400000; cfg_valid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!cfg_ready && n < 100);
    chk_eq("mid_cfg_ready", 64'(cfg_ready), 64'd1);
    chk_eq("mid_cfg_on_tx", 64'(txclk_en), 64'd1);
    chk_eq("mid_cfg_incr", 64'(incr_q), 64'h400000);
    cfg_valid = 1'b0;
    wait_tx(200, n, r);
    chk_eq("tx_period_2p22", 64'(n), 64'd64);

    // Reset while a request is pending.
    repeat (3) @(negedge clk);
    cfg_incr = 24'h200000; cfg_valid = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b1; cfg_valid = 1'b0;
    @(negedge clk);
    chk_eq("rst_pend_ready", 64'(cfg_ready), 64'd0);
    chk_eq("rst_pend_incr", 64'(incr_q), 64'd618475);
    rst = 1'b0;
    @(negedge clk);
    chk_eq("rst_pend_ready_after", 64'(cfg_ready), 64'd0);

    // Zero increment never ticks.
    enable = 1'b0;
    repeat (2) @(negedge clk);
    cfg_incr = '0; cfg_valid = 1'b1;
    @(negedge clk);
    chk_eq("zero_cfg_ready", 64'(cfg_ready), 64'd1);
    cfg_valid = 1'b0; enable = 1'b1;
    cnt = 0;
    repeat (60) begin @(negedge clk); cnt += int'(rxclk_en) + int'(txclk_en); end
    chk_eq("zero_incr_no_ticks", 64'(cnt), 64'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 12000; i++) begin
      @(negedge clk);
      if (cfg_valid && cfg_ready) cfg_valid = 1'b0;
      rst       = ($urandom_range(0, 1499) == 0);
      rx_resync = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 149) == 0) enable = ~enable;
      if (!cfg_valid && $urandom_range(0, 59) == 0) begin
        cfg_incr  = rand_incr();
        cfg_valid = 1'b1;
      end else if (cfg_valid && $urandom_range(0, 199) == 0) begin
        cfg_valid = 1'b0;
      end
    end
    rst = 1'b0; rx_resync = 1'b0; cfg_valid = 1'b0;
    @(negedge clk);
    chk_on = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
